// File: rtl/savemem_pkg.sv
// savemem upload: shared state encoding, half-word select helper
// and SDRAM word size for the upload path.
package savemem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PREF,
    DRAIN
  } state_t;

  localparam int unsigned SDR_WORD_BYTES = 4;

  // Same half order the download path packs with.
  function automatic logic [15:0] half_sel(
    input logic [31:0] w,
    input logic        hi
  );
    return hi ? w[31:16] : w[15:0];
  endfunction

endpackage

// File: rtl/savemem_wordcache.sv
// savemem upload: single 32-bit word register with tag and
// valid bit, plus the hit compare against a lookup tag.
module savemem_wordcache
  import savemem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        wr,
  input  logic [24:0] wr_tag,
  input  logic [31:0] wr_data,
  input  logic [24:0] rd_tag,
  output logic        hit,
  output logic [31:0] data
);

  logic        valid;
  logic [24:0] tag;

  // Invalidate wins over a fill in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end
  end

  assign hit = valid && (tag == rd_tag);

endmodule

// File: rtl/savemem_upload.sv
// savemem upload: streams SDRAM back over the 16-bit hps_io port.
// SAVEMEM_UPLOAD_PREFETCH_EN adds a next-word prefetch register.
module savemem_upload
  import savemem_pkg::*;
#(
  parameter logic [26:0] BASE_ADDR    = 27'h0800000,
  parameter logic [26:0] SIZE_BYTES   = 27'h0020000,
  parameter logic [5:0]  UPLOAD_INDEX = 6'd2
) (
  input  logic        clk1x,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [26:0] ioctl_addr,
  output logic [15:0] ioctl_din,
  output logic        ioctl_wait,
  output logic        sdr_req,
  output logic        sdr_rnw,
  output logic [26:0] sdr_addr,
  input  logic        sdr_ready,
  input  logic [31:0] sdr_dout,
  output logic        busy
);

  state_t      state, state_n;
  logic        active, active_q, rise;
  logic [15:0] din_n;
  logic        wait_n, req_n;
  logic [26:0] addr_n;
  logic [26:0] off_q, off_n;
  logic        pend_q, pend_n;
  logic [26:0] r_off;
  logic [24:0] r_tag;
  logic        r_hi, oob;
  logic        c_hit, c_wr, c_clr;
  logic [31:0] c_data;
  logic        hit_any;
  logic [31:0] hit_word;
  logic        unused_bits;

  assign active = ioctl_upload &&
                  (ioctl_index[5:0] == UPLOAD_INDEX);
  assign rise   = active && !active_q;

  // A read held during PREF is replayed from off_q.
  assign r_off = pend_q ? off_q : ioctl_addr;
  assign r_tag = r_off[26:2];
  assign r_hi  = r_off[1];
  assign oob   = (r_off >= SIZE_BYTES);

  assign sdr_rnw = 1'b1;
  assign busy    = (state != IDLE);

  assign unused_bits = ^{ioctl_index[7:6], r_off[0]};

  savemem_wordcache u_word (
    .clk     (clk1x),
    .reset_n (reset_n),
    .clr     (c_clr),
    .wr      (c_wr),
    .wr_tag  (off_q[26:2]),
    .wr_data (sdr_dout),
    .rd_tag  (r_tag),
    .hit     (c_hit),
    .data    (c_data)
  );

`ifdef SAVEMEM_UPLOAD_PREFETCH_EN
  logic        p_hit, p_wr, p_clr;
  logic [31:0] p_data;
  logic [24:0] pf_q, pf_n;
  logic [24:0] nt_r, nt_o;
  logic        ok_r, ok_o;

  assign nt_r = r_tag + 25'd1;
  assign nt_o = off_q[26:2] + 25'd1;
  assign ok_r = ({1'b0, r_tag, 2'b00} +
                 28'(SDR_WORD_BYTES)) <
                {1'b0, SIZE_BYTES};
  assign ok_o = ({1'b0, off_q[26:2], 2'b00} +
                 28'(SDR_WORD_BYTES)) <
                {1'b0, SIZE_BYTES};

  savemem_wordcache u_pref (
    .clk     (clk1x),
    .reset_n (reset_n),
    .clr     (p_clr),
    .wr      (p_wr),
    .wr_tag  (pf_q),
    .wr_data (sdr_dout),
    .rd_tag  (r_tag),
    .hit     (p_hit),
    .data    (p_data)
  );

  assign hit_any  = c_hit | p_hit;
  assign hit_word = c_hit ? c_data : p_data;

  // Tag of the word the outstanding prefetch will fill.
  always_ff @(posedge clk1x or negedge reset_n) begin
    if (!reset_n) pf_q <= '0;
    else          pf_q <= pf_n;
  end
`else
  assign hit_any  = c_hit;
  assign hit_word = c_data;
`endif

  // State and registered outputs.
  always_ff @(posedge clk1x or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      active_q   <= 1'b0;
      ioctl_din  <= '0;
      ioctl_wait <= 1'b0;
      sdr_req    <= 1'b0;
      sdr_addr   <= '0;
      off_q      <= '0;
      pend_q     <= 1'b0;
    end else begin
      state      <= state_n;
      active_q   <= active;
      ioctl_din  <= din_n;
      ioctl_wait <= wait_n;
      sdr_req    <= req_n;
      sdr_addr   <= addr_n;
      off_q      <= off_n;
      pend_q     <= pend_n;
    end
  end

  // Next state, next outputs and cache strobes.
  always_comb begin
    state_n = state;
    din_n   = ioctl_din;
    wait_n  = ioctl_wait;
    req_n   = 1'b0;
    addr_n  = sdr_addr;
    off_n   = off_q;
    pend_n  = pend_q;
    c_wr    = 1'b0;
    c_clr   = rise;
`ifdef SAVEMEM_UPLOAD_PREFETCH_EN
    p_wr    = 1'b0;
    p_clr   = rise;
    pf_n    = pf_q;
`endif
    unique case (state)
      IDLE: begin
        if (active && (pend_q || ioctl_rd)) begin
          pend_n = 1'b0;
          if (oob) begin
            din_n  = 16'hFFFF;
            wait_n = 1'b0;
          end else if (hit_any && !rise) begin
            din_n  = half_sel(hit_word, r_hi);
            wait_n = 1'b0;
`ifdef SAVEMEM_UPLOAD_PREFETCH_EN
            if (r_hi && ok_r) begin
              req_n   = 1'b1;
              addr_n  = BASE_ADDR + {nt_r, 2'b00};
              pf_n    = nt_r;
              state_n = PREF;
            end
`endif
          end else begin
            req_n   = 1'b1;
            wait_n  = 1'b1;
            addr_n  = BASE_ADDR + {r_tag, 2'b00};
            off_n   = r_off;
            state_n = WAIT;
          end
        end else if (pend_q) begin
          pend_n = 1'b0;
          wait_n = 1'b0;
        end
      end
      WAIT: begin
        if (sdr_ready) begin
          c_wr    = 1'b1;
          din_n   = half_sel(sdr_dout, off_q[1]);
          wait_n  = 1'b0;
          state_n = IDLE;
`ifdef SAVEMEM_UPLOAD_PREFETCH_EN
          if (off_q[1] && ok_o) begin
            req_n   = 1'b1;
            addr_n  = BASE_ADDR + {nt_o, 2'b00};
            pf_n    = nt_o;
            state_n = PREF;
          end
`endif
        end else if (!active) begin
          wait_n  = 1'b0;
          state_n = DRAIN;
        end
      end
`ifdef SAVEMEM_UPLOAD_PREFETCH_EN
      PREF: begin
        if (ioctl_rd && active && !pend_q) begin
          pend_n = 1'b1;
          off_n  = ioctl_addr;
          wait_n = 1'b1;
        end
        if (sdr_ready) begin
          p_wr    = 1'b1;
          state_n = IDLE;
        end else if (!active) begin
          pend_n  = 1'b0;
          wait_n  = 1'b0;
          state_n = DRAIN;
        end
      end
`endif
      DRAIN: begin
        wait_n = 1'b0;
        if (sdr_ready) begin
          c_clr   = 1'b1;
`ifdef SAVEMEM_UPLOAD_PREFETCH_EN
          p_clr   = 1'b1;
`endif
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/savemem_upload.md
# savemem_upload

Read-side counterpart of the cartridge/save download path: streams a region of SDRAM back to the HPS over the hps_io 16-bit upload port. Each 32-bit SDRAM read is split into two 16-bit upload words in the same half-word order the download path uses to pack them. The block sits beside the download logic and drives one SDRAM read channel.

## Interface
Parameters:
- BASE_ADDR, 27'h0800000: SDRAM byte address of upload offset 0.
- SIZE_BYTES, 27'h0020000: region length; offsets at or above it read as 16'hFFFF with no SDRAM access.
- UPLOAD_INDEX, 6'd2: ioctl_index[5:0] value this block responds to.

Ports:
- clk1x in 1: system clock.
- reset_n in 1: asynchronous, active-low reset.
- ioctl_upload in 1: hps_io upload active.
- ioctl_index in 8: selected file index.
- ioctl_rd in 1: one-cycle read strobe.
- ioctl_addr in 27: byte offset, even.
- ioctl_din out 16: upload data.
- ioctl_wait out 1: stall hps_io.
- sdr_req out 1: one-cycle read request pulse.
- sdr_rnw out 1: constant 1.
- sdr_addr out 27: 32-bit-aligned byte address.
- sdr_ready in 1: one-cycle completion pulse.
- sdr_dout in 32: read data, valid with sdr_ready.
- busy out 1: state machine not idle.

## Operation
- Active = ioctl_upload & (ioctl_index[5:0] == UPLOAD_INDEX). Rising edge of active invalidates the word cache.
- Word cache: one 32-bit data register with a tag (ioctl_addr[26:2]) and a valid bit.
- Half select:
  - ioctl_addr[1]=0 returns cache[15:0].
  - ioctl_addr[1]=1 returns cache[31:16].
- Address: sdr_addr = BASE_ADDR + {ioctl_addr[26:2], 2'b00}, computed modulo 2^27 (wraps silently).
- States:
  - IDLE: on ioctl_rd while active:
    - offset >= SIZE_BYTES: load ioctl_din=16'hFFFF; cache untouched; stay IDLE.
    - tag hit and valid: load the selected half; stay IDLE.
    - miss: pulse sdr_req, set ioctl_wait, go WAIT.
  - WAIT: on sdr_ready, write cache and tag, set valid, load the selected half, clear ioctl_wait, go IDLE.
  - DRAIN: entered from WAIT when active drops. On sdr_ready, discard the data, clear valid, go IDLE. ioctl_wait is 0 throughout.
- ioctl_rd outside IDLE is a protocol violation: ignored, no state change.
- ioctl_rd while not active is ignored.

## Timing
- Reset values: ioctl_din=0, ioctl_wait=0, sdr_req=0, sdr_addr=0, sdr_rnw=1, busy=0, cache valid=0, state IDLE.
- Hit or out-of-range: ioctl_din is updated on the first clk1x edge after the ioctl_rd cycle; ioctl_wait stays 0.
- Miss:
  - sdr_req and ioctl_wait rise on the first edge after ioctl_rd; sdr_addr is valid in the same cycle and held until sdr_ready.
  - On the edge after sdr_ready: ioctl_din is valid and ioctl_wait falls in the same cycle.
  - Minimum miss latency is 2 cycles plus the SDRAM latency.
- At most one SDRAM request is outstanding.
- sdr_ready and an active drop in the same cycle: the read completes normally (data accepted), then IDLE.
- Reset asserted mid-read: all state clears immediately. A late sdr_ready arriving after reset is ignored in IDLE.

## Configuration
- SAVEMEM_UPLOAD_PREFETCH_EN defined:
  - After returning the upper half (addr[1]=1) of any word, the block issues a read of the next word (tag+1), only if that word is within SIZE_BYTES.
  - Prefetch uses state PREF and writes a separate prefetch register with its own tag and valid bit.
  - Prefetch register is checked as a second hit source.
  - ioctl_rd during PREF: set ioctl_wait and hold the request. On sdr_ready, serve it from the prefetch register if it hits, otherwise issue a normal miss.
  - Active drop during PREF enters DRAIN.
- Macro undefined: no PREF state, no prefetch register, no speculative reads.

## Structure
- Shared package savemem_pkg:
  - state enum (IDLE, WAIT, PREF, DRAIN);
  - half-select helper function;
  - constant SDR_WORD_BYTES=4.
- Parameters stay per-instance.
- One natural sub-module: savemem_wordcache, holding the tag/data/valid registers with hit compare, instanced once (twice with prefetch).

## Test plan
- Cold miss: upload index 2, rd at addr 0, SDRAM returns 32'hBEEF_CAFE after 5 cycles. Expect:
  - sdr_addr = 27'h0800000;
  - ioctl_wait high for 6 cycles;
  - ioctl_din = 16'hCAFE.
- Hit: then rd at addr 2. Expect ioctl_din = 16'hBEEF one cycle later, no sdr_req, wait stays 0.
- Bounds and wrap:
  - rd at addr 27'h0020000: expect 16'hFFFF, no sdr_req.
  - BASE_ADDR = 27'h7FFFFFC, rd addr 4: expect sdr_addr = 0.
- Abort: drop ioctl_upload in WAIT. Expect:
  - DRAIN;
  - sdr_ready discarded;
  - the next upload session's rd at addr 0 misses and issues a fresh sdr_req.
- Reset: assert reset_n=0 during WAIT. Expect all outputs at reset values in the same cycle, then a stray sdr_ready is ignored.
- Prefetch (macro on):
  - rd addr 2 triggers sdr_req at sdr_addr 27'h0800004;
  - rd addr 4 after completion hits with no stall;
  - rd addr 4 issued mid-PREF stalls, then is served from the prefetch register.
